// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// per-pipeline-register write/flush control pair.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_BUSY  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic write;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping. Used for the data-memory watchdog and the perf counters.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Count enabled cycles; clear has priority, hold once saturated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: turns hazard, data-memory and multi-cycle EX
// handshakes into per-register write/flush controls for the 5-stage core.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; hazard stall/flush applied combinationally
// MEM_WAIT | data memory access outstanding, whole pipe frozen
// MC_BUSY  | multi-cycle EX op running, front end held, bubbles into MEM
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WAIT_MAX = 255,
  parameter int WDT_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       hz_stall,
  input  logic       hz_flush,
  input  logic       MEM_mem_req,
  input  logic       dmem_ready,
  input  logic       EX_mc_start,
  input  logic       EX_mc_done,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_write,
  output logic       ID_EX_flush,
  output logic       EX_MEM_write,
  output logic       EX_MEM_flush,
  output logic       MEM_WB_write,
  output logic       MEM_WB_flush,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] perf_stall_cnt,
  output logic [DATA_WIDTH-1:0] perf_flush_cnt,
  output logic [DATA_WIDTH-1:0] perf_memwait_cnt
`endif
);

  if (DATA_WIDTH < 1 || (64'd1 << WDT_WIDTH) <= 64'(MEM_WAIT_MAX)) begin : g_bad_params
    $error("pipeline_ctrl: DATA_WIDTH must be >= 1 and 2**WDT_WIDTH must exceed MEM_WAIT_MAX");
  end

  localparam logic [WDT_WIDTH:0] WAIT_MAX_W = (WDT_WIDTH+1)'(MEM_WAIT_MAX);

  ctrl_state_t          state_q, state_nxt;
  stage_ctrl_t          if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
  logic                 pc_w;
  logic                 mem_stall, mc_stall, wdt_hit;
  logic [WDT_WIDTH-1:0] wdt_cnt;

  // A MEM_WAIT is held purely on dmem_ready, so a deferred flush stays parked.
  assign mem_stall = ((state_q == MEM_WAIT) || MEM_mem_req) && !dmem_ready;
  assign mc_stall  = ((state_q == MC_BUSY) || EX_mc_start) && !EX_mc_done;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_nxt;
  end

  // Next state and stage controls; priority mem wait > flush > multi-cycle > stall.
  always_comb begin
    pc_w      = 1'b1;
    if_id_c   = '{write: 1'b1, flush: 1'b0};
    id_ex_c   = '{write: 1'b1, flush: 1'b0};
    ex_mem_c  = '{write: 1'b1, flush: 1'b0};
    mem_wb_c  = '{write: 1'b1, flush: 1'b0};
    state_nxt = RUN;
    if (mem_stall) begin
      pc_w           = 1'b0;
      if_id_c.write  = 1'b0;
      id_ex_c.write  = 1'b0;
      ex_mem_c.write = 1'b0;
      mem_wb_c       = '{write: 1'b0, flush: 1'b1};
      // A memory freeze inside MC_BUSY must not lose track of the EX op.
      state_nxt      = (state_q == MC_BUSY) ? MC_BUSY : MEM_WAIT;
    end else if (hz_flush) begin
      if_id_c.flush  = 1'b1;
      id_ex_c.flush  = 1'b1;
      ex_mem_c.flush = 1'b1;
    end else if (mc_stall) begin
      pc_w           = 1'b0;
      if_id_c.write  = 1'b0;
      id_ex_c.write  = 1'b0;
      ex_mem_c.flush = 1'b1;
      state_nxt      = MC_BUSY;
    end else if (hz_stall) begin
      pc_w           = 1'b0;
      if_id_c.write  = 1'b0;
      id_ex_c.flush  = 1'b1;
    end
  end

  // Watchdog counts every frozen memory-wait cycle and clears on release.
  sat_counter #(.WIDTH(WDT_WIDTH)) u_wdt (
    .clk  (clk),
    .rstn (rstn),
    .en   (mem_stall),
    .clr  (!mem_stall),
    .cnt  (wdt_cnt)
  );

  assign wdt_hit = (MEM_WAIT_MAX != 0) && mem_stall &&
                   (({1'b0, wdt_cnt} + 1'b1) >= WAIT_MAX_W);

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        mem_timeout <= 1'b0;
    else if (wdt_hit) mem_timeout <= 1'b1;
  end

  // Controls are forced inactive while reset is asserted, without waiting for a clock.
  assign pc_write     = rstn & pc_w;
  assign IF_ID_write  = rstn & if_id_c.write;
  assign IF_ID_flush  = rstn & if_id_c.flush;
  assign ID_EX_write  = rstn & id_ex_c.write;
  assign ID_EX_flush  = rstn & id_ex_c.flush;
  assign EX_MEM_write = rstn & ex_mem_c.write;
  assign EX_MEM_flush = rstn & ex_mem_c.flush;
  assign MEM_WB_write = rstn & mem_wb_c.write;
  assign MEM_WB_flush = rstn & mem_wb_c.flush;
  assign ctrl_state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_taken, flush_taken;

  assign flush_taken = !mem_stall && hz_flush;
  assign stall_taken = !mem_stall && !hz_flush && !mc_stall && hz_stall;

  sat_counter #(.WIDTH(DATA_WIDTH)) u_perf_stall (
    .clk  (clk),
    .rstn (rstn),
    .en   (stall_taken),
    .clr  (1'b0),
    .cnt  (perf_stall_cnt)
  );

  sat_counter #(.WIDTH(DATA_WIDTH)) u_perf_flush (
    .clk  (clk),
    .rstn (rstn),
    .en   (flush_taken),
    .clr  (1'b0),
    .cnt  (perf_flush_cnt)
  );

  sat_counter #(.WIDTH(DATA_WIDTH)) u_perf_memwait (
    .clk  (clk),
    .rstn (rstn),
    .en   (state_q == MEM_WAIT),
    .clr  (1'b0),
    .cnt  (perf_memwait_cnt)
  );
`endif

endmodule
